// File: rtl/orb_orient_pkg.sv
// orb_orient_pkg: shared constants, boundary tables and FSM states for the orientation quantiser
//   BW_IDX, N_BIN, BW_TRIG : index width, bin count, boundary constant width
//   C_TAB / S_TAB          : round(cos/sin(j*pi/50) * 2^11) for j = 1..24, entry 0 unused
//   state_t                : IDLE -> SEARCH -> DONE -> IDLE
package orb_orient_pkg;
   localparam int BW_IDX  = 5;
   localparam int N_BIN   = 25;
   localparam int BW_TRIG = 12;
   localparam logic [BW_TRIG-1:0] C_TAB [N_BIN] = '{
      12'd0,    12'd2044, 12'd2032, 12'd2012, 12'd1984, 12'd1948, 12'd1904, 12'd1853,
      12'd1795, 12'd1729, 12'd1657, 12'd1578, 12'd1493, 12'd1402, 12'd1305, 12'd1204,
      12'd1097, 12'd987,  12'd872,  12'd754,  12'd633,  12'd509,  12'd384,  12'd257,
      12'd129
   };
   localparam logic [BW_TRIG-1:0] S_TAB [N_BIN] = '{
      12'd0,    12'd129,  12'd257,  12'd384,  12'd509,  12'd633,  12'd754,  12'd872,
      12'd987,  12'd1097, 12'd1204, 12'd1305, 12'd1402, 12'd1493, 12'd1578, 12'd1657,
      12'd1729, 12'd1795, 12'd1853, 12'd1904, 12'd1948, 12'd1984, 12'd2012, 12'd2032,
      12'd2044
   };
   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
endpackage

// File: rtl/orient_boundary_lut.sv
// orient_boundary_lut: combinational boundary lookup, mid -> {C[mid], S[mid]}
//   mid   : boundary number 1..24 (codes outside the table return 0)
//   c, s  : Q1.11 cos/sin of the boundary angle
module orient_boundary_lut
   import orb_orient_pkg::*;
(
   input  logic [BW_IDX-1:0]  mid,
   output logic [BW_TRIG-1:0] c,
   output logic [BW_TRIG-1:0] s
);
   always_comb begin
      c = (int'(mid) < N_BIN) ? C_TAB[mid] : '0;
      s = (int'(mid) < N_BIN) ? S_TAB[mid] : '0;
   end
endmodule

// File: rtl/orientation_bin_search.sv
// orientation_bin_search: folds (m10, m01) into quadrant I and binary-searches the pi/50 angle bin
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : moment pair handshake, accepted only in IDLE
//   m10, m01                 : signed centroid moments
//   out_valid/out_ready      : result handshake, held in DONE until taken
//   out_index                : bin 0..24
//   out_cos_neg, out_sin_neg : quadrant sign flags for the downstream cos/sin LUT
module orientation_bin_search
   import orb_orient_pkg::*;
#(
   parameter int BW_M = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [BW_M-1:0] m10,
   input  logic signed [BW_M-1:0] m01,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BW_IDX-1:0]      out_index,
   output logic                   out_cos_neg,
   output logic                   out_sin_neg
);
   state_t                    state, state_nx;
   logic [BW_M-1:0]           ax, ay;
   logic                      cos_neg, sin_neg, zero;
   logic [BW_IDX-1:0]         lo, hi, mid;
   logic [BW_IDX:0]           mid_sum;
   logic [2:0]                iter;
   logic [BW_TRIG-1:0]        c_mid, s_mid;
   logic [BW_M+BW_TRIG-1:0]   lhs, rhs;
   logic                      ge;
   orient_boundary_lut u_lut (.mid(mid), .c(c_mid), .s(s_mid));
   // One extra bit so lo+hi+1 cannot wrap before the halving
   assign mid_sum = {1'b0, lo} + {1'b0, hi} + {{BW_IDX{1'b0}}, 1'b1};
   assign mid     = mid_sum[BW_IDX:1];
   // Angle >= boundary  <=>  ay*cos(b) >= ax*sin(b), full-width products
   assign lhs = ay * c_mid;
   assign rhs = ax * s_mid;
   assign ge  = lhs >= rhs;
   assign in_ready    = state == IDLE;
   assign out_valid   = state == DONE;
   assign out_index   = zero ? '0 : lo;
   assign out_cos_neg = cos_neg & ~zero;
   assign out_sin_neg = sin_neg & ~zero;
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE && in_valid)      ? SEARCH :
                 (state == SEARCH && iter == 3'd4) ? DONE   :
                 (state == DONE && out_ready)      ? IDLE   : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ax      <= '0;
         ay      <= '0;
         cos_neg <= 1'b0;
         sin_neg <= 1'b0;
         zero    <= 1'b0;
         lo      <= '0;
         hi      <= '0;
         iter    <= '0;
      end else begin
         state <= state_nx;
         if (in_valid && in_ready) begin
            // Two's-complement negate keeps |-2^(BW_M-1)| exact as an unsigned value
            ax      <= m10[BW_M-1] ? (~m10 + 1'b1) : m10;
            ay      <= m01[BW_M-1] ? (~m01 + 1'b1) : m01;
            cos_neg <= m10[BW_M-1];
            sin_neg <= m01[BW_M-1];
            zero    <= (m10 == '0) && (m01 == '0);
            lo      <= '0;
            hi      <= BW_IDX'(N_BIN - 1);
            iter    <= '0;
         end else if (state == SEARCH) begin
            if (lo != hi) begin
               lo <= ge ? mid : lo;
               hi <= ge ? hi : mid - BW_IDX'(1);
            end
            iter <= iter + 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_orientation_bin_search.sv
// tb_orientation_bin_search: directed and random checks of orientation_bin_search against an atan2 model
module tb_orientation_bin_search;
   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [19:0] m10 = '0;
   logic signed [19:0] m01 = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [4:0]         out_index;
   logic               out_cos_neg, out_sin_neg;
   int                 n_assert = 0;
   int                 n_fail = 0;
   int                 cyc = 0;
   localparam real PI = 3.14159265358979323846;
   orientation_bin_search dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .m10(m10), .m01(m01), .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_cos_neg(out_cos_neg), .out_sin_neg(out_sin_neg)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic wait_ready();
      int w;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
         step();
         w++;
      end
   endtask
   task automatic wait_out(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
   endtask
   // Reference: floor(atan2(|y|,|x|)/(pi/50)) clamped to 24; alt is the neighbouring bin
   // that is also acceptable when the angle lies within a hair of a boundary.
   function automatic void model(input logic signed [19:0] x, input logic signed [19:0] y,
                                 output int idx, output int alt, output bit cn, output bit sn);
      real ax, ay, q;
      int f, r;
      if (x == 0 && y == 0) begin
         idx = 0; alt = 0; cn = 0; sn = 0;
         return;
      end
      cn = x < 0;
      sn = y < 0;
      ax = (x < 0) ? -$itor(x) : $itor(x);
      ay = (y < 0) ? -$itor(y) : $itor(y);
      q  = $atan2(ay, ax) / (PI / 50.0);
      f  = int'($floor(q));
      if (f > 24) f = 24;
      r  = int'($floor(q + 0.5));
      idx = f;
      alt = f;
      if ((q - r) < 0.02 && (r - q) < 0.02) begin
         alt = (f == r) ? r - 1 : r;
         if (alt < 0) alt = 0;
         if (alt > 24) alt = 24;
      end
   endfunction
   task automatic do_pair(input string tag, input logic signed [19:0] x, input logic signed [19:0] y,
                          input int e_idx, input bit e_cn, input bit e_sn);
      int lat;
      wait_ready();
      m10 = x; m01 = y; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      m10 = 20'($urandom); m01 = 20'($urandom);
      wait_out(lat);
      chk({tag, " latency"}, lat, 5);
      chk({tag, " index"}, out_index, e_idx);
      chk({tag, " cos_neg"}, out_cos_neg, e_cn);
      chk({tag, " sin_neg"}, out_sin_neg, e_sn);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask
   initial begin
      int lat, acc, prev_acc, e_idx, e_alt, exp_idx;
      bit e_cn, e_sn;
      logic signed [19:0] x, y;
      logic [4:0] held;
      repeat (3) step();
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_index", out_index, 0);
      chk("reset flags", {out_cos_neg, out_sin_neg}, 0);
      rst = 1'b0;
      step();
      do_pair("east", 20'sd1000, 20'sd0, 0, 0, 0);
      do_pair("north", 20'sd0, 20'sd1000, 24, 0, 0);
      do_pair("south", 20'sd0, -20'sd1000, 24, 0, 1);
      do_pair("deg30", 20'sd866, 20'sd500, 8, 0, 0);
      do_pair("deg135", -20'sd1000, 20'sd1000, 12, 1, 0);
      do_pair("deg210", -20'sd866, -20'sd500, 8, 1, 1);
      do_pair("zero", 20'sd0, 20'sd0, 0, 0, 0);
      do_pair("extreme", -20'sd524288, -20'sd524288, 12, 1, 1);
      // Backpressure: result must hold and new inputs must be refused
      wait_ready();
      m10 = -20'sd866; m01 = -20'sd500; in_valid = 1'b1;
      step();
      m10 = 20'sd1000; m01 = 20'sd0;
      wait_out(lat);
      chk("bp latency", lat, 5);
      held = out_index;
      chk("bp index", held, 8);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp out_valid", out_valid, 1);
         chk("bp in_ready", in_ready, 0);
         chk("bp stable", {out_index, out_cos_neg, out_sin_neg}, {5'd8, 2'b11});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp release in_ready", in_ready, 1);
      chk("bp release out_valid", out_valid, 0);
      // Reset during SEARCH discards the result
      wait_ready();
      m10 = 20'sd1000; m01 = 20'sd1000; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst out_valid", out_valid, 0);
      chk("midrst in_ready", in_ready, 1);
      do_pair("after rst", 20'sd866, 20'sd500, 8, 0, 0);
      // Streaming with in_valid and out_ready held high
      in_valid = 1'b1;
      out_ready = 1'b1;
      prev_acc = 0;
      for (int i = 0; i < 50; i++) begin
         x = 20'($urandom);
         y = 20'($urandom);
         if (i == 0) begin x = 0; y = 0; end
         if (i == 1) x = 0;
         if (i == 2) y = 0;
         if (i == 3) begin x = -20'sd524288; y = 20'sd1; end
         wait_ready();
         m10 = x; m01 = y;
         step();
         acc = cyc;
         m10 = 20'($urandom); m01 = 20'($urandom);
         wait_out(lat);
         chk("stream latency", cyc - acc, 5);
         if (i > 0) chk("stream period", acc - prev_acc, 7);
         prev_acc = acc;
         model(x, y, e_idx, e_alt, e_cn, e_sn);
         exp_idx = (int'(out_index) == e_alt) ? e_alt : e_idx;
         chk("stream index", out_index, exp_idx);
         chk("stream flags", {out_cos_neg, out_sin_neg}, {e_cn, e_sn});
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/orientation_bin_search.md
# orientation_bin_search

Sequential orientation quantiser for the ORB keypoint path. It takes the intensity-centroid moments (m10, m01) of one keypoint patch and folds the vector into the first quadrant. A 5-step binary search then finds the 25-way angle bin, each bin π/50 wide. The 5-bit bin index and two sign flags feed the cos/sin angle LUT stage directly downstream, which steers the BRIEF pattern: cos = ±LUT_cos[index], sin = ±LUT_sin[index].

## Interface
- BW_M, 20, width of signed moment inputs
- BW_IDX, 5, bin index width
- N_BIN, 25, number of bins over [0, π/2]
- BW_TRIG, 12, width of unsigned Q1.11 boundary cos/sin constants
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  moment pair valid
- in_ready  out  1  block can accept a pair
- m10  in  BW_M  signed x-moment
- m01  in  BW_M  signed y-moment
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_index  out  BW_IDX  bin 0..24
- out_cos_neg  out  1  m10 < 0
- out_sin_neg  out  1  m01 < 0

## Operation
- **FSM states:** IDLE → SEARCH → DONE → IDLE.
- **Accept:** in_ready = (state == IDLE). An input is accepted on an edge with in_valid && in_ready.
- **On accept, register:**
  - ax = |m10| and ay = |m01|, each BW_M bits unsigned. The magnitude of -2^(BW_M-1) is 2^(BW_M-1) and must not saturate.
  - cos_neg = m10[MSB], sin_neg = m01[MSB].
  - zero = (m10 == 0 && m01 == 0).
  - lo = 0, hi = 24, iter = 0.
- **Boundaries:** b_j = j·π/50 for j = 1..24.
- **Each SEARCH cycle:**
  - mid = (lo + hi + 1) >> 1.
  - ge = ay·C[mid] >= ax·S[mid], using unsigned products of BW_M+BW_TRIG bits with no truncation. C[j] = round(cos b_j · 2^11), S[j] = round(sin b_j · 2^11).
  - If lo == hi, hold lo and hi. Otherwise, if ge then lo = mid, else hi = mid − 1.
  - iter increments. After 5 iterations (iter == 4 at the edge), go to DONE.
- **Result:**
  - out_index = zero ? 0 : lo.
  - out_cos_neg and out_sin_neg are the registered flags, with both forced to 0 when zero.
- **DONE:** out_valid is high. Outputs are held stable until out_valid && out_ready, then the FSM returns to IDLE.
- **Angle rule:** an angle exactly on a boundary belongs to the upper bin (≥ comparison).
- **Axis cases:**
  - m10 = 0, m01 ≠ 0 → index 24.
  - m01 = 0, m10 ≠ 0 → index 0.

## Timing
- **Reset values:** state = IDLE, in_ready = 1, out_valid = 0, out_index = 0, out_cos_neg = 0, out_sin_neg = 0. All internal registers are cleared.
- **Latency:** accept on edge E0; search steps on E1..E5; out_valid is high after E5, i.e. 5 cycles after the accepting edge.
- **Throughput:** with out_ready held high, the output handshake occurs on E6 and the next accept on E7, giving 1 result per 7 cycles.
- **Backpressure:**
  - out_ready low holds DONE indefinitely with stable outputs.
  - in_ready stays low, so inputs are ignored and never lost or overwritten.
- **Same-edge events:** the output handshake and the return to IDLE happen on one edge. No accept can occur in that same cycle.
- **Reset mid-operation:** rst in SEARCH or DONE returns to IDLE on the next edge. The in-flight result is discarded, and out_valid is 0 in the following cycle.
- **Input hold:** m10 and m01 are sampled only at the accept edge and may change afterward.

## Structure
- **Package orb_orient_pkg holds:**
  - N_BIN, BW_IDX, BW_TRIG.
  - The 24-entry C[] and S[] boundary constant arrays (Q1.11; index 0 unused).
  - The FSM state enum.
- **Sub-module orient_boundary_lut:** combinational; maps mid (5 bits) → {C[mid], S[mid]}.
- **Top block contains:** the FSM, magnitude/sign capture, two multipliers, comparator, and lo/hi/iter registers.
- **Size estimate:** roughly 150–250 lines of RTL.

## Test plan
- **Cardinal directions:** (m10, m01) = (1000, 0) → index 0, flags 00. (0, 1000) → index 24, flags 00. (0, −1000) → index 24, sin_neg = 1.
- **Mid-range angles:**
  - (866, 500), 30° → index 8.
  - (−1000, 1000), 45° → index 12, cos_neg = 1, sin_neg = 0.
  - (−866, −500) → index 8, both flags 1.
- **Zero vector and extremes:**
  - (0, 0) → index 0, flags 00.
  - (−524288, −524288) → index 12, flags 11, with no overflow.
- **Backpressure:**
  - Hold out_ready = 0 for 10 cycles after out_valid. Outputs stay stable and in_ready stays 0.
  - Then pulse out_ready. in_ready rises on the next cycle.
- **Throughput and latency:** stream 50 random pairs with in_valid and out_ready held high. Expect exactly one result per 7 cycles and out_valid 5 cycles after each accept. Results match a floor(atan2(|m01|, |m10|) / (π/50)) reference model, clamped to 24, except at exact-boundary ties.
- **Reset mid-search:** assert rst 2 cycles after an accept. The next cycle shows IDLE with out_valid = 0 and in_ready = 1. A following input (866, 500) → index 8.
